// File: rtl/barrel_spawner.sv
// barrel_spawner: launches barrels into four slots on Kong drop events and moves them roll/fall/retire.
// Optional feature macro: BARREL_RETIRE_COUNT_EN builds the saturating retired-barrel counter.
module barrel_spawner #(
    parameter int SPAWN_X   = 160,
    parameter int SPAWN_Y   = 100,
    parameter int X_MIN     = 16,
    parameter int X_MAX     = 600,
    parameter int SPEED     = 2,
    parameter int FLOOR_GAP = 64,
    parameter int Y_BOTTOM  = 420
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        kong_state,
    input  logic [1:0]  kong_anim,
    input  logic        tick,
    output logic [3:0]  barrel_valid,
    output logic [39:0] barrel_x,
    output logic [35:0] barrel_y,
    output logic [3:0]  barrel_falling,
    output logic        spawn_miss,
    output logic        retire,
    output logic [7:0]  retired_count
);
    // bit 0 = slot active, bit 1 = falling, so both outputs come straight off flops
    localparam logic [1:0] IDLE = 2'b00, ROLL = 2'b01, FALL = 2'b11;
    logic [1:0] st[4], st_n[4];
    logic [9:0] x[4], x_n[4];
    logic [8:0] y[4], y_n[4];
    logic       dir[4], dir_n[4];
    logic [6:0] cnt[4], cnt_n[4];
    logic [1:0] prev_anim;
    logic [3:0] ret_n;
    logic [1:0] slot;
    logic       free, drop;
    assign drop = kong_state && kong_anim == 2'b11 && prev_anim != 2'b11;
    // lowest-index slot that was idle before this edge
    always_comb begin
        free = 1'b0;
        slot = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (!st[i][0]) begin
                free = 1'b1;
                slot = 2'(i);
            end
    end
    // next-state: per-slot movement on tick, then a spawn overrides the claimed idle slot
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            st_n[i]  = st[i];
            x_n[i]   = x[i];
            y_n[i]   = y[i];
            dir_n[i] = dir[i];
            cnt_n[i] = cnt[i];
            ret_n[i] = 1'b0;
            if (tick && st[i] == ROLL) begin
                if (!dir[i]) begin
                    if ({1'b0, x[i]} + 11'(SPEED) >= 11'(X_MAX)) begin
                        x_n[i]   = 10'(X_MAX);
                        cnt_n[i] = 7'd0;
                        st_n[i]  = FALL;
                    end else
                        x_n[i] = x[i] + 10'(SPEED);
                end else begin
                    if ({1'b0, x[i]} <= 11'(X_MIN + SPEED)) begin
                        x_n[i]   = 10'(X_MIN);
                        cnt_n[i] = 7'd0;
                        st_n[i]  = FALL;
                    end else
                        x_n[i] = x[i] - 10'(SPEED);
                end
            end else if (tick && st[i] == FALL) begin
                y_n[i]   = y[i] + 9'd1;
                cnt_n[i] = cnt[i] + 7'd1;
                if (cnt[i] == 7'(FLOOR_GAP - 1)) begin
                    if ({1'b0, y[i]} + 10'd1 >= 10'(Y_BOTTOM)) begin
                        st_n[i]  = IDLE;
                        x_n[i]   = 10'd0;
                        y_n[i]   = 9'd0;
                        dir_n[i] = 1'b0;
                        ret_n[i] = 1'b1;
                    end else begin
                        dir_n[i] = ~dir[i];
                        st_n[i]  = ROLL;
                    end
                end
            end
            if (drop && free && slot == 2'(i)) begin
                st_n[i]  = ROLL;
                x_n[i]   = 10'(SPAWN_X);
                y_n[i]   = 9'(SPAWN_Y);
                dir_n[i] = 1'b0;
                cnt_n[i] = 7'd0;
            end
        end
    end
    // state register; leaving play clears everything like a reset
    always_ff @(posedge clk) begin
        if (rst || !kong_state) begin
            for (int i = 0; i < 4; i++) begin
                st[i]  <= IDLE;
                x[i]   <= 10'd0;
                y[i]   <= 9'd0;
                dir[i] <= 1'b0;
                cnt[i] <= 7'd0;
            end
            prev_anim  <= 2'b00;
            spawn_miss <= 1'b0;
            retire     <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                st[i]  <= st_n[i];
                x[i]   <= x_n[i];
                y[i]   <= y_n[i];
                dir[i] <= dir_n[i];
                cnt[i] <= cnt_n[i];
            end
            prev_anim  <= kong_anim;
            spawn_miss <= drop && !free;
            retire     <= |ret_n;
        end
    end
    // output packing of the slot registers
    always_comb begin
        barrel_valid   = '0;
        barrel_falling = '0;
        barrel_x       = '0;
        barrel_y       = '0;
        for (int i = 0; i < 4; i++) begin
            barrel_valid[i]     = st[i][0];
            barrel_falling[i]   = st[i][1];
            barrel_x[10*i +: 10] = x[i];
            barrel_y[9*i +: 9]   = y[i];
        end
    end
`ifdef BARREL_RETIRE_COUNT_EN
    logic [2:0] n_ret;
    assign n_ret = 3'(ret_n[0]) + 3'(ret_n[1]) + 3'(ret_n[2]) + 3'(ret_n[3]);
    // saturating retire counter, survives game over
    always_ff @(posedge clk) begin
        if (rst)
            retired_count <= 8'd0;
        else if (kong_state)
            retired_count <= (9'(retired_count) + 9'(n_ret) > 9'd255) ? 8'd255 : retired_count + 8'(n_ret);
    end
`else
    assign retired_count = 8'd0;
`endif
endmodule

// File: tb/tb_barrel_spawner.sv
// tb_barrel_spawner: directed scoreboard bench for barrel_spawner (default and low-Y_BOTTOM instances).
module tb_barrel_spawner;
    logic        clk = 1'b0;
    logic        rst, kong_state, tick;
    logic [1:0]  kong_anim;
    logic [3:0]  barrel_valid, barrel_falling, r_valid, r_falling;
    logic [39:0] barrel_x, r_x;
    logic [35:0] barrel_y, r_y;
    logic        spawn_miss, retire, r_miss, r_retire;
    logic [7:0]  retired_count, r_count;
    int total = 0;
    int bad = 0;
`ifdef BARREL_RETIRE_COUNT_EN
    localparam logic [7:0] EXP_CNT = 8'd1;
`else
    localparam logic [7:0] EXP_CNT = 8'd0;
`endif
    typedef struct {
        string      tag;
        logic [3:0] v;
        int         slot;
        logic [9:0] x;
        logic [8:0] y;
    } exp_t;
    exp_t sb[$];

    barrel_spawner dut (
        .clk(clk), .rst(rst), .kong_state(kong_state), .kong_anim(kong_anim), .tick(tick),
        .barrel_valid(barrel_valid), .barrel_x(barrel_x), .barrel_y(barrel_y),
        .barrel_falling(barrel_falling), .spawn_miss(spawn_miss), .retire(retire),
        .retired_count(retired_count)
    );
    barrel_spawner #(.Y_BOTTOM(164)) dut_r (
        .clk(clk), .rst(rst), .kong_state(kong_state), .kong_anim(kong_anim), .tick(tick),
        .barrel_valid(r_valid), .barrel_x(r_x), .barrel_y(r_y),
        .barrel_falling(r_falling), .spawn_miss(r_miss), .retire(r_retire),
        .retired_count(r_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_chk;
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_valid"}, 64'(barrel_valid), 64'(e.v));
        chk({e.tag, "_x"}, 64'(barrel_x[10*e.slot +: 10]), 64'(e.x));
        chk({e.tag, "_y"}, 64'(barrel_y[9*e.slot +: 9]), 64'(e.y));
    endtask

    initial begin
        rst = 1'b1; kong_state = 1'b0; kong_anim = 2'b00; tick = 1'b0;
        step; step;
        chk("rst_valid", 64'(barrel_valid), 0);
        chk("rst_x", 64'(barrel_x), 0);
        chk("rst_y", 64'(barrel_y), 0);
        chk("rst_falling", 64'(barrel_falling), 0);
        chk("rst_pulses", 64'({spawn_miss, retire}), 0);
        chk("rst_count", 64'(retired_count), 0);
        rst = 1'b0; kong_state = 1'b1; step;
        kong_anim = 2'b11;
        sb.push_back(exp_t'{"spawn1", 4'b0001, 0, 10'd160, 9'd100});
        step; pop_chk;
        chk("spawn1_miss", 64'(spawn_miss), 0);
        for (int k = 0; k < 9; k++) begin
            step;
            chk("held_valid", 64'(barrel_valid), 64'(4'b0001));
        end
        kong_anim = 2'b00; step;
        for (int k = 1; k < 4; k++) begin
            kong_anim = 2'b11;
            sb.push_back(exp_t'{$sformatf("spawn%0d", k + 1), 4'((1 << (k + 1)) - 1), k, 10'd160, 9'd100});
            step; pop_chk;
            chk("fill_miss", 64'(spawn_miss), 0);
            kong_anim = 2'b00; step;
        end
        kong_anim = 2'b11; step;
        chk("miss5", 64'(spawn_miss), 1);
        chk("miss5_valid", 64'(barrel_valid), 64'(4'b1111));
        kong_anim = 2'b00; step;
        chk("miss5_drop", 64'(spawn_miss), 0);
        kong_state = 1'b0; step;
        chk("gameover_valid", 64'(barrel_valid), 0);
        chk("gameover_x", 64'(barrel_x), 0);
        chk("gameover_count", 64'(retired_count), 0);
        chk("gameover_r_valid", 64'(r_valid), 0);
        rst = 1'b1; step;
        rst = 1'b0; kong_state = 1'b1; step;
        kong_anim = 2'b11;
        sb.push_back(exp_t'{"edge_spawn", 4'b0001, 0, 10'd160, 9'd100});
        step; pop_chk;
        kong_anim = 2'b00; tick = 1'b1;
        for (int k = 1; k <= 220; k++) begin
            step;
            chk("roll_x", 64'(barrel_x[9:0]), 64'(160 + 2 * k));
            chk("roll_falling", 64'(barrel_falling[0]), 64'(k == 220));
        end
        for (int k = 1; k <= 64; k++) begin
            step;
            chk("fall_y", 64'(barrel_y[8:0]), 64'(100 + k));
            chk("fall_falling", 64'(barrel_falling[0]), 64'(k < 64));
            chk("fall_r_valid", 64'(r_valid[0]), 64'(k < 64));
            chk("fall_r_retire", 64'(r_retire), 64'(k == 64));
        end
        chk("land_valid", 64'(barrel_valid), 64'(4'b0001));
        chk("land_x", 64'(barrel_x[9:0]), 600);
        chk("land_retire", 64'(retire), 0);
        chk("r_count", 64'(r_count), 64'(EXP_CNT));
        step;
        chk("left_x", 64'(barrel_x[9:0]), 598);
        chk("r_retire_drop", 64'(r_retire), 0);
        kong_anim = 2'b11;
        sb.push_back(exp_t'{"tick_spawn", 4'b0011, 1, 10'd160, 9'd100});
        step; pop_chk;
        chk("tick_spawn_old_x", 64'(barrel_x[9:0]), 596);
        chk("tick_spawn_r_valid", 64'(r_valid), 64'(4'b0001));
        chk("tick_spawn_r_x", 64'(r_x[9:0]), 160);
        kong_anim = 2'b00; tick = 1'b0; kong_state = 1'b0; step;
        kong_anim = 2'b11; step;
        chk("clear_drop_valid", 64'(barrel_valid), 0);
        chk("clear_drop_miss", 64'(spawn_miss), 0);
        chk("clear_r_count", 64'(r_count), 64'(EXP_CNT));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
